// File: rtl/alu_rs_cluster_pkg.sv
// Shared definitions for the ALU reservation-station cluster: opcodes, ALU
// sequencing states and the combinational ALU function.
package alu_rs_cluster_pkg;

    localparam int TAG_NONE  = 0;
    localparam int ALU_MAX_W = 64;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ALU_IDLE = 2'd0,
        ALU_EXEC = 2'd1,
        ALU_DONE = 2'd2
    } alu_state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op != 3'b010) && (op != 3'b011);
    endfunction

    // Computed at the widest supported width; callers truncate, which keeps
    // add/sub wrapping modulo 2^DATA_W for any DATA_W up to ALU_MAX_W.
    function automatic logic [ALU_MAX_W-1:0] alu_compute(
        input logic [2:0]           op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b
    );
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_NOT:  return ~a;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rs_cluster_rr_arbiter.sv
// Round-robin picker: grants the first requester at or after the pointer,
// wrapping around the N requesters.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             valid_o
);

    logic [PTR_W-1:0] idx;

    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int off = 0; off < N; off++) begin
            idx = PTR_W'((int'(ptr_i) + off) % N);
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs_cluster.sv
// Tomasulo functional-unit cluster: NUM_RS reservation stations with CDB
// snooping in front of one multi-cycle ALU that requests the CDB for results.
module alu_rs_cluster
    import alu_rs_cluster_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6,
    parameter int NUM_RS  = 3,
    parameter int RS_BASE = 1,
    parameter int LATENCY = 4
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              issue_i,
    input  logic [2:0]        issue_op_i,
    input  logic [DATA_W-1:0] issue_vj_i,
    input  logic [DATA_W-1:0] issue_vk_i,
    input  logic [TAG_W-1:0]  issue_qj_i,
    input  logic [TAG_W-1:0]  issue_qk_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    input  logic              cdb_grant_i,
    output logic              available_o,
    output logic [TAG_W-1:0]  issue_tag_o,
    output logic              error_o,
    output logic              cdb_req_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [NUM_RS-1:0] rs_busy_o,
    output logic [TAG_W-1:0]  rs_executing_o
);

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

    // Station storage
    logic [NUM_RS-1:0] busy_q;
    logic [2:0]        op_q [NUM_RS];
    logic [DATA_W-1:0] vj_q [NUM_RS];
    logic [DATA_W-1:0] vk_q [NUM_RS];
    logic [TAG_W-1:0]  qj_q [NUM_RS];
    logic [TAG_W-1:0]  qk_q [NUM_RS];

    logic [PTR_W-1:0]  alloc_ptr_q;
    logic [PTR_W-1:0]  disp_ptr_q;
    logic [TAG_W-1:0]  issue_tag_q;
    logic              error_q;

    // ALU state
    alu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  exec_idx_q;
    logic [TAG_W-1:0]  exec_tag_q;
    logic [DATA_W-1:0] result_q;

    logic [NUM_RS-1:0] alloc_grant, disp_grant;
    logic              alloc_valid, disp_valid;
    logic [PTR_W-1:0]  alloc_idx, disp_idx;
    logic [NUM_RS-1:0] ready, snoop_j, snoop_k;
    logic              issue_accept, bypass_j, bypass_k;
    logic              dispatch, grant_done;

    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NUM_RS-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (oh[i]) idx = idx | PTR_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_RS - 1)) ? '0 : PTR_W'(idx + 1'b1);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [PTR_W-1:0] idx);
        return TAG_W'(RS_BASE) + TAG_W'(idx);
    endfunction

    rr_arbiter #(.N(NUM_RS), .PTR_W(PTR_W)) u_alloc_arb (
        .req_i   (~busy_q),
        .ptr_i   (alloc_ptr_q),
        .grant_o (alloc_grant),
        .valid_o (alloc_valid)
    );

    rr_arbiter #(.N(NUM_RS), .PTR_W(PTR_W)) u_disp_arb (
        .req_i   (ready),
        .ptr_i   (disp_ptr_q),
        .grant_o (disp_grant),
        .valid_o (disp_valid)
    );

    assign alloc_idx = oh_to_idx(alloc_grant);
    assign disp_idx  = oh_to_idx(disp_grant);

    // Allocation only sees registered busy bits, so a station freed by this
    // cycle's grant is not reused until the following cycle.
    assign issue_accept = issue_i && op_legal(issue_op_i) && alloc_valid;
    assign bypass_j     = cdb_valid_i && (issue_qj_i != NO_TAG) && (issue_qj_i == cdb_tag_i);
    assign bypass_k     = cdb_valid_i && (issue_qk_i != NO_TAG) && (issue_qk_i == cdb_tag_i);
    assign dispatch     = (state_q == ALU_IDLE) && disp_valid;
    assign grant_done   = (state_q == ALU_DONE) && cdb_grant_i;

    always_comb begin
        ready   = '0;
        snoop_j = '0;
        snoop_k = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            snoop_j[i] = cdb_valid_i && busy_q[i] && (qj_q[i] != NO_TAG) && (qj_q[i] == cdb_tag_i);
            snoop_k[i] = cdb_valid_i && busy_q[i] && (qk_q[i] != NO_TAG) && (qk_q[i] == cdb_tag_i);
            ready[i]   = busy_q[i] && (qj_q[i] == NO_TAG) && (qk_q[i] == NO_TAG)
                         && !((state_q != ALU_IDLE) && (exec_idx_q == PTR_W'(i)));
        end
    end

    // NOTE: station arrays are reset explicitly; the cluster is small and a
    // clean Q=0/V=0 state after reset keeps snoop matching well defined.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_RS; i++) begin
                op_q[i] <= OP_ADD;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                qj_q[i] <= NO_TAG;
                qk_q[i] <= NO_TAG;
            end
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (issue_accept && alloc_grant[i]) begin
                    busy_q[i] <= 1'b1;
                    op_q[i]   <= issue_op_i;
                    vj_q[i]   <= bypass_j ? cdb_data_i : issue_vj_i;
                    vk_q[i]   <= bypass_k ? cdb_data_i : issue_vk_i;
                    qj_q[i]   <= bypass_j ? NO_TAG : issue_qj_i;
                    qk_q[i]   <= bypass_k ? NO_TAG : issue_qk_i;
                end else begin
                    if (snoop_j[i]) begin
                        vj_q[i] <= cdb_data_i;
                        qj_q[i] <= NO_TAG;
                    end
                    if (snoop_k[i]) begin
                        vk_q[i] <= cdb_data_i;
                        qk_q[i] <= NO_TAG;
                    end
                    if (grant_done && (exec_idx_q == PTR_W'(i))) busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            alloc_ptr_q <= '0;
            issue_tag_q <= NO_TAG;
            error_q     <= 1'b0;
        end else begin
            error_q     <= issue_i && !issue_accept;
            issue_tag_q <= issue_accept ? tag_of(alloc_idx) : NO_TAG;
            if (issue_accept) alloc_ptr_q <= next_ptr(alloc_idx);
        end
    end

    // ALU sequencer: state register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= ALU_IDLE;
        else            state_q <= state_d;
    end

    // ALU sequencer: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ALU_IDLE: if (dispatch)            state_d = ALU_EXEC;
            ALU_EXEC: if (cnt_q == '0)         state_d = ALU_DONE;
            ALU_DONE: if (cdb_grant_i)         state_d = ALU_IDLE;
            default:                           state_d = ALU_IDLE;
        endcase
    end

    // ALU sequencer: outputs
    always_comb begin
        cdb_req_o      = (state_q == ALU_DONE);
        out_tag_o      = cdb_req_o ? exec_tag_q : NO_TAG;
        out_data_o     = cdb_req_o ? result_q : '0;
        rs_executing_o = exec_tag_q;
    end

    // Operands are consumed at dispatch; the counter only models latency.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q      <= '0;
            exec_idx_q <= '0;
            exec_tag_q <= NO_TAG;
            result_q   <= '0;
            disp_ptr_q <= '0;
        end else begin
            if (dispatch) begin
                exec_idx_q <= disp_idx;
                exec_tag_q <= tag_of(disp_idx);
                result_q   <= DATA_W'(alu_compute(op_q[disp_idx],
                                                  ALU_MAX_W'(vj_q[disp_idx]),
                                                  ALU_MAX_W'(vk_q[disp_idx])));
                cnt_q      <= CNT_W'(LATENCY - 1);
                disp_ptr_q <= next_ptr(disp_idx);
            end else if ((state_q == ALU_EXEC) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (grant_done) exec_tag_q <= NO_TAG;
        end
    end

    assign available_o = |(~busy_q);
    assign rs_busy_o   = busy_q;
    assign issue_tag_o = issue_tag_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_alu_rs_cluster.sv
// Directed bench for alu_rs_cluster: allocation, snoop/bypass, round-robin
// dispatch, CDB handshake and asynchronous reset.
module tb_alu_rs_cluster;

    localparam int DW  = 32;
    localparam int TW  = 6;
    localparam int NRS = 3;
    localparam int LAT = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          issue = 1'b0;
    logic [2:0]    issue_op = 3'b000;
    logic [DW-1:0] issue_vj = '0, issue_vk = '0;
    logic [TW-1:0] issue_qj = '0, issue_qk = '0;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [DW-1:0] cdb_data = '0;
    logic          cdb_grant = 1'b0;
    logic          available, error, cdb_req;
    logic [TW-1:0] issue_tag, out_tag, rs_executing;
    logic [DW-1:0] out_data;
    logic [NRS-1:0] rs_busy;

    int pass_cnt = 0;
    int check_cnt = 0;

    alu_rs_cluster #(.DATA_W(DW), .TAG_W(TW), .NUM_RS(NRS), .RS_BASE(1), .LATENCY(LAT)) dut (
        .clock_i(clock), .reset_n_i(reset_n),
        .issue_i(issue), .issue_op_i(issue_op),
        .issue_vj_i(issue_vj), .issue_vk_i(issue_vk),
        .issue_qj_i(issue_qj), .issue_qk_i(issue_qk),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .cdb_grant_i(cdb_grant),
        .available_o(available), .issue_tag_o(issue_tag), .error_o(error),
        .cdb_req_o(cdb_req), .out_tag_o(out_tag), .out_data_o(out_data),
        .rs_busy_o(rs_busy), .rs_executing_o(rs_executing)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; issue = 1'b0; cdb_valid = 1'b0; cdb_grant = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic do_issue(input logic [2:0] op, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                            input logic [TW-1:0] qj, input logic [TW-1:0] qk);
        issue = 1'b1; issue_op = op; issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
        step();
        issue = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (cdb_req !== 1'b1 && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic grant_one();
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        check_cnt++;
        if ({available, error, cdb_req} !== 3'b100) $display("FAIL reset_flags: got %b expected 100", {available, error, cdb_req});
        else pass_cnt++;
        check_cnt++;
        if ({issue_tag, out_tag, rs_executing, rs_busy} !== '0 || out_data !== '0)
            $display("FAIL reset_values: got tag=%0d out_tag=%0d exec=%0d busy=%b data=%0h expected all 0",
                     issue_tag, out_tag, rs_executing, rs_busy, out_data);
        else pass_cnt++;
    endtask

    task automatic test_add();
        int n;
        do_issue(3'b000, 5, 7, 0, 0);
        check_cnt++;
        if (issue_tag !== 6'd1 || rs_busy !== 3'b001) $display("FAIL add_issue: got tag=%0d busy=%b expected 1/001", issue_tag, rs_busy);
        else pass_cnt++;
        cdb_grant = 1'b1;  // must be ignored: no request outstanding
        step();
        cdb_grant = 1'b0;
        check_cnt++;
        if (rs_executing !== 6'd1 || cdb_req !== 1'b0) $display("FAIL add_dispatch: got exec=%0d req=%b expected 1/0", rs_executing, cdb_req);
        else pass_cnt++;
        wait_req(n);
        check_cnt++;
        if (n !== LAT) $display("FAIL add_latency: got %0d cycles expected %0d", n, LAT);
        else pass_cnt++;
        check_cnt++;
        if (out_tag !== 6'd1 || out_data !== 32'd12) $display("FAIL add_result: got tag=%0d data=%0d expected 1/12", out_tag, out_data);
        else pass_cnt++;
        grant_one();
        check_cnt++;
        if (cdb_req !== 1'b0 || rs_busy !== 3'b000 || rs_executing !== 6'd0)
            $display("FAIL add_grant: got req=%b busy=%b exec=%0d expected 0/000/0", cdb_req, rs_busy, rs_executing);
        else pass_cnt++;
    endtask

    task automatic test_wrap_illegal();
        int n;
        do_issue(3'b001, 0, 1, 0, 0);
        check_cnt++;
        if (issue_tag !== 6'd2) $display("FAIL sub_tag: got %0d expected 2", issue_tag);
        else pass_cnt++;
        wait_req(n);
        check_cnt++;
        if (cdb_req !== 1'b1 || out_tag !== 6'd2 || out_data !== 32'hFFFF_FFFF)
            $display("FAIL sub_wrap: got req=%b tag=%0d data=%0h expected 1/2/ffffffff", cdb_req, out_tag, out_data);
        else pass_cnt++;
        grant_one();
        do_issue(3'b010, 1, 1, 0, 0);
        check_cnt++;
        if (error !== 1'b1 || issue_tag !== 6'd0) $display("FAIL illegal_op: got err=%b tag=%0d expected 1/0", error, issue_tag);
        else pass_cnt++;
        step();
        check_cnt++;
        if (error !== 1'b0 || rs_busy !== 3'b000) $display("FAIL illegal_pulse: got err=%b busy=%b expected 0/000", error, rs_busy);
        else pass_cnt++;
    endtask

    task automatic test_fill_rotation();
        int n;
        logic [TW-1:0] exp_tag [3];
        logic [DW-1:0] exp_dat [3];
        exp_tag[0] = 6'd2; exp_tag[1] = 6'd3; exp_tag[2] = 6'd1;
        exp_dat[0] = 32'd2; exp_dat[1] = 32'd6; exp_dat[2] = 32'd101;
        apply_reset();
        do_issue(3'b000, 0, 10, 9, 0);
        check_cnt++;
        if (issue_tag !== 6'd1) $display("FAIL fill_tag1: got %0d expected 1", issue_tag); else pass_cnt++;
        do_issue(3'b001, 0, 1, 9, 0);
        check_cnt++;
        if (issue_tag !== 6'd2) $display("FAIL fill_tag2: got %0d expected 2", issue_tag); else pass_cnt++;
        do_issue(3'b111, 0, 5, 9, 0);
        check_cnt++;
        if (issue_tag !== 6'd3 || available !== 1'b0 || rs_busy !== 3'b111)
            $display("FAIL fill_full: got tag=%0d avail=%b busy=%b expected 3/0/111", issue_tag, available, rs_busy);
        else pass_cnt++;
        do_issue(3'b000, 1, 1, 0, 0);
        check_cnt++;
        if (error !== 1'b1 || issue_tag !== 6'd0) $display("FAIL fill_overflow: got err=%b tag=%0d expected 1/0", error, issue_tag);
        else pass_cnt++;
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'd3;
        step();
        cdb_valid = 1'b0;
        wait_req(n);
        check_cnt++;
        if (out_tag !== 6'd1 || out_data !== 32'd13) $display("FAIL rot_first: got tag=%0d data=%0d expected 1/13", out_tag, out_data);
        else pass_cnt++;
        // Issue in the grant cycle: the station being freed is still busy.
        cdb_grant = 1'b1;
        issue = 1'b1; issue_op = 3'b000; issue_vj = 100; issue_vk = 1; issue_qj = 0; issue_qk = 0;
        step();
        cdb_grant = 1'b0; issue = 1'b0;
        check_cnt++;
        if (error !== 1'b1 || issue_tag !== 6'd0) $display("FAIL grant_cycle_alloc: got err=%b tag=%0d expected 1/0", error, issue_tag);
        else pass_cnt++;
        do_issue(3'b000, 100, 1, 0, 0);
        check_cnt++;
        if (issue_tag !== 6'd1) $display("FAIL realloc_tag: got %0d expected 1", issue_tag); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            wait_req(n);
            check_cnt++;
            if (cdb_req !== 1'b1 || out_tag !== exp_tag[k] || out_data !== exp_dat[k])
                $display("FAIL rot_%0d: got req=%b tag=%0d data=%0d expected 1/%0d/%0d", k, cdb_req, out_tag, out_data, exp_tag[k], exp_dat[k]);
            else pass_cnt++;
            grant_one();
        end
    endtask

    task automatic test_bypass();
        int n;
        apply_reset();
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'd40;
        do_issue(3'b000, 32'd999, 2, 9, 0);
        cdb_valid = 1'b0;
        check_cnt++;
        if (issue_tag !== 6'd1) $display("FAIL bypass_tag: got %0d expected 1", issue_tag); else pass_cnt++;
        step();
        check_cnt++;
        if (rs_executing !== 6'd1) $display("FAIL bypass_dispatch: got exec=%0d expected 1", rs_executing); else pass_cnt++;
        wait_req(n);
        check_cnt++;
        if (n !== LAT || out_data !== 32'd42) $display("FAIL bypass_result: got n=%0d data=%0d expected %0d/42", n, out_data, LAT);
        else pass_cnt++;
        grant_one();
    endtask

    task automatic test_starvation();
        int n;
        logic [DW-1:0] exp_data [4];
        logic [TW-1:0] order [4];
        logic [TW-1:0] t;
        order[0] = 6'd1; order[1] = 6'd2; order[2] = 6'd1; order[3] = 6'd2;
        exp_data[0] = '0; exp_data[1] = 32'd2; exp_data[2] = 32'd4; exp_data[3] = '0;
        apply_reset();
        do_issue(3'b000, 1, 1, 0, 0);
        do_issue(3'b000, 2, 2, 0, 0);
        do_issue(3'b000, 0, 0, 9, 0);
        for (int r = 0; r < 4; r++) begin
            wait_req(n);
            t = order[r];
            check_cnt++;
            if (cdb_req !== 1'b1 || out_tag !== t || out_data !== exp_data[t])
                $display("FAIL starve_round%0d: got req=%b tag=%0d data=%0d expected 1/%0d/%0d", r, cdb_req, out_tag, out_data, t, exp_data[t]);
            else pass_cnt++;
            if (r == 0) begin
                for (int d = 0; d < 5; d++) begin
                    step();
                    check_cnt++;
                    if (cdb_req !== 1'b1 || out_tag !== t || out_data !== exp_data[t])
                        $display("FAIL hold_%0d: got req=%b tag=%0d data=%0d expected 1/%0d/%0d", d, cdb_req, out_tag, out_data, t, exp_data[t]);
                    else pass_cnt++;
                end
            end
            grant_one();
            exp_data[t] = 32'(16 * (r + 1)) + 32'(t);
            do_issue(3'b000, 32'(16 * (r + 1)), 32'(t), 0, 0);
            check_cnt++;
            if (issue_tag !== t) $display("FAIL starve_realloc%0d: got %0d expected %0d", r, issue_tag, t);
            else pass_cnt++;
        end
    endtask

    task automatic test_issue_snoop();
        int n;
        apply_reset();
        do_issue(3'b000, 0, 4, 9, 0);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'd6;
        do_issue(3'b000, 1, 1, 0, 0);
        cdb_valid = 1'b0;
        check_cnt++;
        if (issue_tag !== 6'd2 || rs_busy !== 3'b011) $display("FAIL issue_snoop: got tag=%0d busy=%b expected 2/011", issue_tag, rs_busy);
        else pass_cnt++;
        wait_req(n);
        check_cnt++;
        if (out_tag !== 6'd1 || out_data !== 32'd10) $display("FAIL snoop_result1: got tag=%0d data=%0d expected 1/10", out_tag, out_data);
        else pass_cnt++;
        grant_one();
        wait_req(n);
        check_cnt++;
        if (out_tag !== 6'd2 || out_data !== 32'd2) $display("FAIL snoop_result2: got tag=%0d data=%0d expected 2/2", out_tag, out_data);
        else pass_cnt++;
        grant_one();
    endtask

    task automatic test_async_reset();
        int n;
        do_issue(3'b000, 5, 5, 0, 0);
        check_cnt++;
        if (issue_tag !== 6'd3) $display("FAIL pre_reset_tag: got %0d expected 3", issue_tag); else pass_cnt++;
        step(); step();
        reset_n = 1'b0;
        #1;
        check_cnt++;
        if (cdb_req !== 1'b0 || rs_busy !== 3'b000 || rs_executing !== 6'd0 || available !== 1'b1)
            $display("FAIL reset_exec: got req=%b busy=%b exec=%0d avail=%b expected 0/000/0/1", cdb_req, rs_busy, rs_executing, available);
        else pass_cnt++;
        step();
        reset_n = 1'b1;
        do_issue(3'b000, 3, 4, 0, 0);
        check_cnt++;
        if (issue_tag !== 6'd1) $display("FAIL post_reset_tag: got %0d expected 1", issue_tag); else pass_cnt++;
        wait_req(n);
        check_cnt++;
        if (cdb_req !== 1'b1 || out_data !== 32'd7) $display("FAIL post_reset_result: got req=%b data=%0d expected 1/7", cdb_req, out_data);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        check_cnt++;
        if (cdb_req !== 1'b0 || out_tag !== 6'd0 || out_data !== '0)
            $display("FAIL reset_done: got req=%b tag=%0d data=%0h expected 0/0/0", cdb_req, out_tag, out_data);
        else pass_cnt++;
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap_illegal();
        test_fill_rotation();
        test_bypass();
        test_starvation();
        test_issue_snoop();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/alu_rs_cluster.md
# alu_rs_cluster

Parametrised Tomasulo functional-unit cluster: NUM_RS reservation stations in front of one multi-cycle integer ALU, with CDB snooping, round-robin allocation and dispatch, and a request/grant result handshake to the CDB arbiter. Successor to the fixed three-station adder. Adds configurable width, depth and latency, asynchronous reset, same-cycle CDB bypass at issue, and starvation-free dispatch.

## Interface
- DATA_W, 32, operand/result width
- TAG_W, 6, RS tag width; tag 0 = "value valid / no station"
- NUM_RS, 3, stations in cluster (1..8)
- RS_BASE, 1, tag of station 0; station i has tag RS_BASE+i
- LATENCY, 4, ALU execution cycles (>=1)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- issue  in  1  issue request this cycle
- issue_op  in  3  opcode (rs_pkg encoding)
- issue_vj, issue_vk  in  DATA_W  operand values
- issue_qj, issue_qk  in  TAG_W  producing tags, 0 = value valid
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcasting station
- cdb_data  in  DATA_W  broadcast value
- cdb_grant  in  1  arbiter grant for this cluster
- available  out  1  at least one station free (registered state)
- issue_tag  out  TAG_W  tag allocated by last accepted issue, one-cycle pulse, else 0
- error  out  1  one-cycle pulse: issue rejected (full or illegal opcode)
- cdb_req  out  1  result ready, requesting CDB
- out_tag, out_data  out  TAG_W / DATA_W  result tag/value, stable while cdb_req
- rs_busy  out  NUM_RS  per-station busy
- rs_executing  out  TAG_W  tag in ALU, 0 if idle

## Operation
- Reset: all stations free, Q fields 0, ALU idle, alloc/dispatch pointers 0; outputs available=1, issue_tag=0, error=0, cdb_req=0, out_tag=0, out_data=0, rs_busy=0, rs_executing=0.
- Opcodes: 000 add, 001 sub, 100 or, 101 and, 110 not (~Vj), 111 xor; 010/011 illegal. Arithmetic wraps mod 2^DATA_W, no overflow flag.
- Allocation: on issue with legal op and a free station, take first free station at or after alloc pointer (round-robin); pointer moves to chosen+1 mod NUM_RS. Full or illegal -> no state change, error pulse.
- Issue bypass: if cdb_valid and cdb_tag equals nonzero issue_qj/qk in the issue cycle, capture cdb_data and store Q=0.
- Snoop: every busy station with Qj (Qk) == cdb_tag under cdb_valid captures Vj (Vk) and clears Q at that edge.
- Dispatch: when ALU idle, pick first ready station (busy, Qj=Qk=0, not executing) at or after dispatch pointer; pointer moves to chosen+1. One operation in flight.
- States: IDLE -> EXEC (LATENCY cycles, down-counter) -> DONE (cdb_req=1) -> IDLE on cdb_grant; station freed and rs_executing=0 at grant edge.

## Timing
- Issue accepted at edge N: issue_tag/rs_busy visible after N; earliest dispatch edge N+1; cdb_req rises after edge N+1+LATENCY.
- cdb_req held, out_tag/out_data stable until cdb_grant sampled high; drops the edge after grant. Grant while cdb_req=0 ignored.
- Freed station not reallocatable in its grant cycle (available from registered state); reusable next cycle.
- Next dispatch earliest edge after grant.
- Issue and snoop same edge on different stations: both take effect.
- reset_n low mid-operation: immediate clear to reset values, in-flight result discarded, cdb_req deasserts asynchronously.

## Structure
- rs_pkg: opcode constants, TAG_NONE=0, ALU state enum, alu_compute function.
- Sub-module rr_arbiter (parametrised N, request vector + pointer -> one-hot grant, valid); replaces fixed mod-3 rotation; instantiated for allocation and dispatch.

## Test plan
- Reset then issue add Vj=5, Vk=7, Q=0 -> issue_tag=1; cdb_req after LATENCY+1 cycles, out_tag=1, out_data=12; grant frees station 1.
- Wrap: sub Vj=0, Vk=1 -> out_data=32'hFFFF_FFFF; illegal op 010 -> error pulse, no tag.
- Fill NUM_RS=3 stations with Qj=9 -> available=0; fourth issue -> error; cdb_valid tag 9 data 3 -> all three dispatch in rotation, tags 1,2,3.
- Bypass: issue Qj=9 while cdb_valid, tag 9, data 40 -> dispatch next cycle using 40.
- Starvation: stations 1 and 2 kept ready repeatedly -> dispatch order alternates 1,2,1,2; cdb_grant delayed 5 cycles -> out_data stable throughout.
- reset_n low during EXEC -> cdb_req=0, rs_busy=0 immediately; fresh issue afterwards gets tag 1.
